// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and the round-robin winner search for the 4:1 mux arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First requester found scanning (ptr+1), (ptr+2), (ptr+3), ptr; returns ptr if none.
    function automatic logic [SEL_W-1:0] rr_winner(input logic [NUM_REQ-1:0] req,
                                                   input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] w;
        logic [SEL_W-1:0] idx;
        logic             found;
        w     = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/four_onemuxes.sv
// 4:1 single-bit mux datapath: y = i[s].
module four_onemuxes (
    input  logic [1:0] s,
    input  logic [3:0] i,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (s)
            2'd0:    y = i[0];
            2'd1:    y = i[1];
            2'd2:    y = i[2];
            default: y = i[3];
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with bounded tenure that drives the select of four_onemuxes.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   i,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [SEL_W-1:0]     s,
    output logic                 valid,
    output logic                 y
);

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic [SEL_W-1:0]     s_n;
    logic                 valid_n;
    logic [SEL_W-1:0]     ptr, ptr_n;
    logic [CNT_W-1:0]     hold_cnt, hold_cnt_n;
    logic [SEL_W-1:0]     win;
    logic                 rel;
    logic                 y_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            s        <= '0;
            valid    <= 1'b0;
            ptr      <= SEL_W'(NUM_REQ - 1);
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            s        <= s_n;
            valid    <= valid_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    // While BUSY, ptr and s both hold the current owner index.
    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        s_n        = s;
        valid_n    = valid;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        win        = rr_winner(req, ptr);
        rel        = !req[s] || (hold_cnt == CNT_W'(MAX_HOLD));

        case (state)
            IDLE: begin
                if (|req) begin
                    state_n    = BUSY;
                    gnt_n      = NUM_REQ'(1) << win;
                    s_n        = win;
                    valid_n    = 1'b1;
                    ptr_n      = win;
                    hold_cnt_n = CNT_W'(1);
                end
            end
            BUSY: begin
                if (!rel) begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end else if (|req) begin
                    gnt_n      = NUM_REQ'(1) << win;
                    s_n        = win;
                    ptr_n      = win;
                    hold_cnt_n = CNT_W'(1);
                end else begin
                    state_n    = IDLE;
                    gnt_n      = '0;
                    valid_n    = 1'b0;
                    hold_cnt_n = '0;
                end
            end
            default: begin
                state_n    = IDLE;
                gnt_n      = '0;
                valid_n    = 1'b0;
                hold_cnt_n = '0;
            end
        endcase
    end

    four_onemuxes u_mux (
        .s (s),
        .i (i),
        .y (y_raw)
    );

    assign y = valid & y_raw;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter and select controller for the 4:1 mux datapath (four_onemuxes). Four requesters each present a request line and a data bit. The block grants one requester at a time and drives the mux select so that requester's data bit reaches y. Each tenure is bounded by a hold limit so that no requester can starve the others.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one requester may own the mux (legal range 1..15)
CNT_W, 4, width of the tenure counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  4  request per requester; req[k] belongs to requester k
i    input  4  data bit per requester; i[k] is routed when k is granted
gnt  output 4  one-hot grant, registered
s    output 2  mux select driven to four_onemuxes, registered, equals index of gnt
valid output 1  high while any grant is active, registered
y    output 1  muxed data: i[s] when valid=1, else 0 (combinational from i)

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-high. Asserting rst clears all state immediately, without waiting for a clock edge.
- Reset values:
  - gnt=0000, s=00, valid=0, y=0
  - internal state=IDLE, hold_cnt=0
  - priority pointer ptr=3, so the first search order is 0,1,2,3
- Search order from ptr: (ptr+1)%4, (ptr+2)%4, (ptr+3)%4, ptr. The first index with req set wins.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req==0: stay in IDLE; gnt, valid and hold_cnt stay 0; s holds its last value.
  - If req!=0: on the next edge, gnt=onehot(w), s=w, valid=1, ptr=w, hold_cnt=1, go to BUSY.
  - Latency from req rising to gnt is exactly 1 clock.
- BUSY, owner k:
  - Release condition: req[k]==0 OR hold_cnt==MAX_HOLD.
  - No release: hold_cnt increments; gnt and s are unchanged. Requests from non-owners are ignored.
  - Release with some req bit set (search from ptr=k): on the same edge, switch directly to winner w with gnt=onehot(w), s=w, ptr=w, hold_cnt=1. There is no idle gap cycle.
  - If k is the only requester and it hit the hold limit, k is re-granted. gnt stays the same and hold_cnt restarts at 1.
  - Release with req==0: gnt=0000, valid=0, hold_cnt=0, go to IDLE. s holds its last value.
- Arithmetic: hold_cnt saturates logic at MAX_HOLD; it never wraps. ptr wraps modulo 4.
- Output invariants:
  - gnt is always one-hot or zero.
  - valid == |gnt.
  - s == index(gnt) whenever valid=1.
- y: comes from the four_onemuxes instance with s and i, gated by valid. While valid=1, y follows i[s] combinationally in the same cycle.
- Simultaneous events:
  - An owner dropping req in the same cycle its hold limit is reached is treated as a single release.
  - A new requester asserting in the release cycle is eligible for that arbitration.
- Reset mid-tenure: the grant is lost immediately and ptr returns to 3. After release, the first arbitration favours requester 0.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state enum {IDLE, BUSY}
  - NUM_REQ=4 and SEL_W=2 constants
  - a function returning the round-robin winner index given req and ptr
- Sub-module: existing four_onemuxes instantiated as the datapath (s, i, y_raw); y = valid & y_raw.
- Arbitration, FSM and counter stay in rr_mux_arbiter.

Test Plan (MAX_HOLD=4):
1. Reset: hold rst=1 with req=1111, i=1111 -> gnt=0000, s=00, valid=0, y=0. Drop rst mid-cycle -> first edge gives gnt=0001, s=00, y=1.
2. Lone requester: req=0100, i=0100 held for 10 cycles -> gnt=0100 from cycle 1 onward with no gap. s=10, y=1. hold_cnt cycles 1,2,3,4,1,...
3. Full contention: req=1111 held -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001. Each switch happens in a single edge with valid continuously 1.
4. Early release: owner 1 drops req[1] in its tenure cycle 2 while req[3]=1 -> next edge gnt=1000, s=11, hold_cnt=1. No valid=0 cycle.
5. Return to idle: owner 2 drops and req=0000 -> next edge gnt=0000, valid=0, y=0, s stays 10. Later req=0011 -> grant goes to 0 (search from ptr=2: 3,0,1,2).
6. Async reset mid-tenure: during gnt=0100, pulse rst between edges -> gnt=0000 and valid=0 immediately. With req=1111 after release, the first grant is 0001.
